// File: rtl/pulse_rate_meter_pkg.sv
// Shared constants and FSM encoding for the pulse rate meter.
package pulse_meter_pkg;

  localparam int CNT_W      = 14;
  localparam int SAT_VAL    = 9999;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CONV_RATE  = 2'd1,
    CONV_TOTAL = 2'd2,
    PUBLISH    = 2'd3
  } meter_state_e;

endpackage

// File: rtl/pulse_rate_meter_if.sv
// Pulse input, enable and display-facing results of the rate meter.
interface pulse_rate_meter_if;
  import pulse_meter_pkg::*;

  logic             pulse;
  logic             en;
  logic [BCD_W-1:0] rate_bcd;
  logic [BCD_W-1:0] total_bcd;
  logic             rate_valid;
  logic             overflow;

  modport master (
    output pulse, en,
    input  rate_bcd, total_bcd, rate_valid, overflow
  );

  modport slave (
    input  pulse, en,
    output rate_bcd, total_bcd, rate_valid, overflow
  );

endinterface

// File: rtl/pulse_rate_meter_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock.
// The first step is taken in the start cycle itself, so done arrives
// exactly CNT_W cycles after start is sampled.
module bin2bcd_seq
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = pulse_meter_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  localparam int IT_W = $clog2(CNT_W + 1);

  logic [BCD_W-1:0] bcd_q;
  logic [CNT_W-1:0] bin_q;
  logic [IT_W-1:0]  iter_q;
  logic             done_q;

  logic [BCD_W-1:0] src_bcd;
  logic [CNT_W-1:0] src_bin;
  logic [BCD_W-1:0] adj_bcd;
  logic [BCD_W-1:0] step_bcd;
  logic [CNT_W-1:0] step_bin;

  // One double-dabble step: add 3 to any digit >= 5, then shift left by one.
  always_comb begin
    src_bcd = start ? '0 : bcd_q;
    src_bin = start ? bin : bin_q;
    adj_bcd = src_bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (src_bcd[4*d +: 4] >= 4'd5) begin
        adj_bcd[4*d +: 4] = src_bcd[4*d +: 4] + 4'd3;
      end
    end
    step_bcd = {adj_bcd[BCD_W-2:0], src_bin[CNT_W-1]};
    step_bin = {src_bin[CNT_W-2:0], 1'b0};
  end

  // Iteration down-counter; done pulses once, after the last step lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      iter_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        bcd_q  <= step_bcd;
        bin_q  <= step_bin;
        iter_q <= IT_W'(CNT_W - 1);
      end else if (iter_q != '0) begin
        bcd_q  <= step_bcd;
        bin_q  <= step_bin;
        iter_q <= iter_q - 1'b1;
        if (iter_q == IT_W'(1)) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule

// File: rtl/pulse_rate_meter.sv
// Pulse rate meter: counts rising edges of pulse per fixed window, keeps a
// saturating running total, and publishes both as 4-digit BCD through one
// shared sequential converter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for the window terminal cycle
// CONV_RATE  | converter busy on rate_hold; result stashed on done
// CONV_TOTAL | converter busy on total_hold; outputs loaded on done
// PUBLISH    | new rate/total on the outputs, rate_valid high one cycle
module pulse_rate_meter
  import pulse_meter_pkg::*;
#(
  parameter int WINDOW_CYCLES = 100_000_000,
  parameter int CNT_W         = pulse_meter_pkg::CNT_W,
  parameter int SAT_VAL       = pulse_meter_pkg::SAT_VAL
) (
  input  logic               clk,
  input  logic               rst,
  pulse_rate_meter_if.slave  bus
);

  // The full convert/publish sequence must finish before the next window closes.
  if (WINDOW_CYCLES < 2 * CNT_W + 4) begin : g_window_too_short
    $error("pulse_rate_meter: WINDOW_CYCLES shorter than the conversion sequence");
  end

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT      = CNT_W'(SAT_VAL);

  meter_state_e     state_q, state_d;
  logic             conv_start_q;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic [CNT_W-1:0] conv_bin;

  logic             pulse_q;
  logic             pulse_edge;
  logic             win_end;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] rate_acc, rate_next, rate_hold;
  logic [CNT_W-1:0] total, total_next, total_hold;
  logic             overflow_q;

  logic [BCD_W-1:0] rate_stash;
  logic [BCD_W-1:0] rate_bcd_q;
  logic [BCD_W-1:0] total_bcd_q;

  // Edge detect, terminal-cycle decode and saturating increments.
  always_comb begin
    pulse_edge = bus.en & bus.pulse & ~pulse_q;
    win_end    = bus.en && (win_cnt == WIN_LAST);
    rate_next  = (pulse_edge && (rate_acc != SAT)) ? rate_acc + 1'b1 : rate_acc;
    total_next = (pulse_edge && (total != SAT)) ? total + 1'b1 : total;
  end

  // Window counter, accumulators and terminal-cycle snapshots.
  // pulse_q resets high so a pulse already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q    <= 1'b1;
      win_cnt    <= '0;
      rate_acc   <= '0;
      total      <= '0;
      rate_hold  <= '0;
      total_hold <= '0;
      overflow_q <= 1'b0;
    end else begin
      pulse_q <= bus.pulse;
      total   <= total_next;
      if (pulse_edge && (total == SAT)) begin
        overflow_q <= 1'b1;
      end
      if (!bus.en) begin
        win_cnt  <= '0;
        rate_acc <= '0;
      end else if (win_end) begin
        win_cnt    <= '0;
        rate_acc   <= '0;
        rate_hold  <= rate_next;
        total_hold <= total_next;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        rate_acc <= rate_next;
      end
    end
  end

  // Next-state logic for the convert/publish sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (win_end)   state_d = CONV_RATE;
      CONV_RATE:  if (conv_done) state_d = CONV_TOTAL;
      CONV_TOTAL: if (conv_done) state_d = PUBLISH;
      PUBLISH:                   state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // State register; conv_start is a one-cycle pulse on entry to a convert state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      conv_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      conv_start_q <= (state_d != state_q) &&
                      ((state_d == CONV_RATE) || (state_d == CONV_TOTAL));
    end
  end

  assign conv_bin = (state_q == CONV_TOTAL) ? total_hold : rate_hold;

  bin2bcd_seq #(
    .CNT_W (CNT_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start_q),
    .bin   (conv_bin),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // Capture converter results; both outputs change together entering PUBLISH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_stash  <= '0;
      rate_bcd_q  <= '0;
      total_bcd_q <= '0;
    end else if (conv_done) begin
      if (state_q == CONV_RATE) begin
        rate_stash <= conv_bcd;
      end else if (state_q == CONV_TOTAL) begin
        rate_bcd_q  <= rate_stash;
        total_bcd_q <= conv_bcd;
      end
    end
  end

  assign bus.rate_bcd   = rate_bcd_q;
  assign bus.total_bcd  = total_bcd_q;
  assign bus.rate_valid = (state_q == PUBLISH);
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Testbench for pulse_rate_meter with a 100-cycle window. Every driven cycle
// is logged; expected rates and totals are recomputed from that log by
// counting rising edges over window and since-reset cycle ranges.
module tb_pulse_rate_meter;

  localparam int W   = 100;
  localparam int CW  = 14;
  localparam int LAT = 2 * CW + 3;
  localparam int SAT = 9999;

  logic clk = 1'b0;
  logic rst;

  pulse_rate_meter_if bus ();

  pulse_rate_meter #(
    .WINDOW_CYCLES (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rst_base   = 0;
  int last_start = 0;
  logic [15:0] last_exp_rate  = '0;
  logic [15:0] last_exp_total = '0;

  bit pulse_h[$];
  bit en_h[$];
  bit rst_h[$];
  int          sv_cyc[$];
  logic [15:0] sv_rate[$];
  logic [15:0] sv_tot[$];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Rising edges in cycles a..b that the meter should count: en high, not in
  // reset, and the cycle after a reset never starts an edge.
  function automatic int count_edges(input int a, input int b);
    int n = 0;
    bit prev;
    for (int c = a; c <= b; c++) begin
      if (c == 0) prev = 1'b1;
      else if (rst_h[c-1]) prev = 1'b1;
      else prev = pulse_h[c-1];
      if (en_h[c] && !rst_h[c] && pulse_h[c] && !prev) n++;
    end
    return n;
  endfunction

  // Log this cycle's inputs, advance one clock, record any strobe.
  task automatic tick();
    pulse_h.push_back(bus.pulse);
    en_h.push_back(bus.en);
    rst_h.push_back(rst);
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rate_valid === 1'b1) begin
      sv_cyc.push_back(cyc);
      sv_rate.push_back(bus.rate_bcd);
      sv_tot.push_back(bus.total_bcd);
    end
  endtask

  task automatic clear_strobes();
    sv_cyc.delete();
    sv_rate.delete();
    sv_tot.delete();
  endtask

  // Enable for nwin full windows (+ latency), then check every published window.
  // mode: 0 period-10, 1 toggle, 2 random, 3 held high, 4 single edge at first terminal cycle
  task automatic test_windows(input int mode, input int nwin);
    int s, t_end, exp_r, exp_t, raw;
    s = cyc;
    last_start = s;
    clear_strobes();
    bus.en = 1'b1;
    for (int n = 0; n <= nwin * W + LAT; n++) begin
      case (mode)
        0:       bus.pulse = ((n % 10) >= 5);
        1:       bus.pulse = n[0];
        2:       bus.pulse = ($urandom_range(0, 2) == 0);
        3:       bus.pulse = 1'b1;
        default: bus.pulse = (n == W - 1);
      endcase
      tick();
    end
    bus.en    = 1'b0;
    bus.pulse = 1'b0;
    tick();
    checks++;
    if (sv_cyc.size() != nwin) begin
      errors++;
      $display("FAIL strobe_count mode=%0d: got %0d, expected %0d", mode, sv_cyc.size(), nwin);
    end
    for (int k = 0; k < nwin && k < sv_cyc.size(); k++) begin
      t_end = s + (k + 1) * W - 1;
      exp_r = count_edges(t_end - W + 1, t_end);
      if (exp_r > SAT) exp_r = SAT;
      exp_t = count_edges(rst_base, t_end);
      if (exp_t > SAT) exp_t = SAT;
      checks++;
      if (sv_cyc[k] != t_end + LAT) begin
        errors++;
        $display("FAIL strobe_time win=%0d: got cycle %0d, expected %0d", k, sv_cyc[k], t_end + LAT);
      end
      checks++;
      if (sv_rate[k] !== to_bcd(exp_r)) begin
        errors++;
        $display("FAIL rate_bcd win=%0d: got %h, expected %h", k, sv_rate[k], to_bcd(exp_r));
      end
      checks++;
      if (sv_tot[k] !== to_bcd(exp_t)) begin
        errors++;
        $display("FAIL total_bcd win=%0d: got %h, expected %h", k, sv_tot[k], to_bcd(exp_t));
      end
      last_exp_rate  = to_bcd(exp_r);
      last_exp_total = to_bcd(exp_t);
    end
    raw = count_edges(rst_base, cyc - 1);
    checks++;
    if (bus.overflow !== (raw > SAT)) begin
      errors++;
      $display("FAIL overflow: got %b, expected %b (raw edges %0d)", bus.overflow, raw > SAT, raw);
    end
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
    rst_base = cyc;
  endtask

  task automatic test_reset();
    bus.pulse = 1'b1;
    bus.en    = 1'b0;
    reset_dut(3);
    checks++;
    if (bus.rate_bcd !== 16'h0 || bus.total_bcd !== 16'h0) begin
      errors++;
      $display("FAIL reset_bcd: got rate %h total %h, expected 0000 0000", bus.rate_bcd, bus.total_bcd);
    end
    checks++;
    if (bus.rate_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid %b overflow %b, expected 0 0", bus.rate_valid, bus.overflow);
    end
    test_windows(3, 1);
    checks++;
    if (sv_rate[0] !== 16'h0000 || sv_tot[0] !== 16'h0000) begin
      errors++;
      $display("FAIL reset_no_edge: got rate %h total %h, expected 0000 0000", sv_rate[0], sv_tot[0]);
    end
  endtask

  task automatic test_period10();
    test_windows(0, 2);
    checks++;
    if (sv_cyc[0] - last_start != W - 1 + LAT) begin
      errors++;
      $display("FAIL first_strobe_latency: got %0d, expected %0d", sv_cyc[0] - last_start, W - 1 + LAT);
    end
    checks++;
    if (sv_rate[0] !== 16'h0010 || sv_tot[0] !== 16'h0010 || sv_tot[1] !== 16'h0020) begin
      errors++;
      $display("FAIL period10: got rate %h totals %h %h, expected 0010 0010 0020",
               sv_rate[0], sv_tot[0], sv_tot[1]);
    end
  endtask

  task automatic test_terminal_edge();
    test_windows(4, 2);
    checks++;
    if (sv_rate[0] !== 16'h0001 || sv_rate[1] !== 16'h0000) begin
      errors++;
      $display("FAIL terminal_edge: got rates %h %h, expected 0001 0000", sv_rate[0], sv_rate[1]);
    end
  endtask

  task automatic test_en_off();
    clear_strobes();
    bus.en = 1'b0;
    for (int i = 0; i < 500; i++) begin
      bus.pulse = ($urandom_range(0, 1) == 1);
      tick();
    end
    checks++;
    if (sv_cyc.size() != 0) begin
      errors++;
      $display("FAIL en_off_strobe: got %0d strobes, expected 0", sv_cyc.size());
    end
    checks++;
    if (bus.total_bcd !== last_exp_total || bus.rate_bcd !== last_exp_rate) begin
      errors++;
      $display("FAIL en_off_hold: got rate %h total %h, expected %h %h",
               bus.rate_bcd, bus.total_bcd, last_exp_rate, last_exp_total);
    end
    test_windows(2, 1);
    checks++;
    if (sv_cyc[0] - last_start != W - 1 + LAT) begin
      errors++;
      $display("FAIL reenable_latency: got %0d, expected %0d", sv_cyc[0] - last_start, W - 1 + LAT);
    end
  endtask

  task automatic test_rst_mid();
    int s;
    s = cyc;
    clear_strobes();
    bus.en = 1'b1;
    for (int n = 0; n < W + 9; n++) begin
      bus.pulse = ((n % 10) >= 5);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rst_base = cyc;
    checks++;
    if (bus.rate_bcd !== 16'h0 || bus.total_bcd !== 16'h0 ||
        bus.rate_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got rate %h total %h valid %b ovf %b, expected all 0",
               bus.rate_bcd, bus.total_bcd, bus.rate_valid, bus.overflow);
    end
    bus.en    = 1'b0;
    bus.pulse = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (sv_cyc.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_strobe: got %0d strobes after cycle %0d, expected 0", sv_cyc.size(), s);
    end
    test_windows(2, 2);
  endtask

  task automatic test_saturation();
    bus.en    = 1'b0;
    bus.pulse = 1'b0;
    reset_dut(2);
    test_windows(1, 201);
    checks++;
    if (sv_rate[0] !== 16'h0050 || sv_tot[198] !== 16'h9950 ||
        sv_tot[199] !== 16'h9999 || sv_tot[200] !== 16'h9999) begin
      errors++;
      $display("FAIL saturation: got rate %h totals %h %h %h, expected 0050 9950 9999 9999",
               sv_rate[0], sv_tot[198], sv_tot[199], sv_tot[200]);
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b, expected 1", bus.overflow);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.pulse = 1'b1;
    bus.en    = 1'b0;
    test_reset();
    test_period10();
    test_windows(2, 3);
    test_terminal_edge();
    test_en_off();
    test_rst_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
